// File: rtl/prefetch_pkg.sv
// Shared prefetch types: the address width and the entry layouts used by the
// prefetcher, the issue queue and the in-flight table.
package prefetch_pkg;

  localparam int DEFAULT_ADDR_W = 16;

  typedef struct packed {
    logic                      live;
    logic [DEFAULT_ADDR_W-1:0] addr;
  } pf_entry_t;

  typedef struct packed {
    logic                      valid;
    logic [DEFAULT_ADDR_W-1:0] addr;
  } inflight_entry_t;

endpackage

// File: rtl/prefetch_issue_queue_if.sv
// Memory-side prefetch port: request handshake plus the returning response.
interface prefetch_issue_queue_if
  import prefetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              memReqValid;
  logic [ADDR_W-1:0] memReqAddr;
  logic              memReqReady;
  logic              memRespValid;
  logic [ADDR_W-1:0] memRespAddr;

  modport master (
    output memReqValid, memReqAddr,
    input  memReqReady, memRespValid, memRespAddr
  );

  modport slave (
    input  memReqValid, memReqAddr,
    output memReqReady, memRespValid, memRespAddr
  );

endinterface

// File: rtl/pf_inflight_table.sv
// CAM of outstanding prefetches: allocates the lowest free slot, frees by
// address, and answers a lookup used for duplicate suppression.
module pf_inflight_table
  import prefetch_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int INFLIGHT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        allocValid,
  input  logic [ADDR_W-1:0]           allocAddr,
  input  logic                        freeValid,
  input  logic [ADDR_W-1:0]           freeAddr,
  input  logic [ADDR_W-1:0]           lookupAddr,
  output logic                        lookupHit,
  output logic [$clog2(INFLIGHT):0]   count
);

  localparam int IDX_W = $clog2(INFLIGHT);

  inflight_entry_t  slots [INFLIGHT];
  logic [IDX_W-1:0] allocIdx;
  logic             freeHit;

  // NOTE: every output of this block gets a default before the loop, so no latch is inferred.
  always_comb begin
    lookupHit = 1'b0;
    freeHit   = 1'b0;
    allocIdx  = '0;
    for (int i = INFLIGHT - 1; i >= 0; i--) begin
      if (!slots[i].valid) allocIdx = IDX_W'(i);
      if (slots[i].valid && slots[i].addr == lookupAddr) lookupHit = 1'b1;
      if (freeValid && slots[i].valid && slots[i].addr == freeAddr) freeHit = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so the free loop and the
  // allocation both see pre-edge slot contents and cannot race.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INFLIGHT; i++) slots[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < INFLIGHT; i++) begin
        if (freeValid && slots[i].valid && slots[i].addr == freeAddr) slots[i].valid <= 1'b0;
      end
      // allocIdx is judged on pre-edge valid bits, so it never lands on a slot freed this cycle
      if (allocValid) slots[allocIdx] <= '{valid: 1'b1, addr: allocAddr};
      case ({allocValid, freeHit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: dedups and buffers prefetch addresses, cancels those a
// demand access already covered, and issues the rest to memory.
module prefetch_issue_queue
  import prefetch_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DEPTH    = 8,
  parameter int INFLIGHT = 4,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pfReq,
  input  logic [ADDR_W-1:0]          pfAddr,
  input  logic                       demandAccess,
  input  logic [ADDR_W-1:0]          demandAddr,
  prefetch_issue_queue_if.master     mem,
  output logic [$clog2(DEPTH):0]     queueCount,
  output logic [$clog2(INFLIGHT):0]  inflightCount,
  output logic [CNT_W-1:0]           dropCount
);

  localparam int PTR_W = $clog2(DEPTH);

  pf_entry_t        queue [DEPTH];
  pf_entry_t        headEntry;
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [PTR_W:0]   count;
  logic             queueHit;
  logic             inflightHit;
  logic             enqueue;
  logic             drop;
  logic             pop;
  logic             issue;
  logic             reqValid;

  assign headEntry = queue[headPtr];
  // Derived from registered state only; the head cannot be squashed while presented.
  assign reqValid  = headEntry.live && (int'(inflightCount) < INFLIGHT);
  assign issue     = reqValid && mem.memReqReady;
  assign pop       = (count != '0) && (!headEntry.live || issue);

  always_comb begin
    queueHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (queue[i].live && queue[i].addr == pfAddr) queueHit = 1'b1;
    end
  end

  assign enqueue = pfReq && (int'(count) != DEPTH) && !queueHit && !inflightHit
                   && !(demandAccess && demandAddr == pfAddr);
  assign drop    = pfReq && !enqueue;

  // NOTE: the queue is small and its live bits must start clear, so whole entries are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) queue[i] <= '0;
      headPtr   <= '0;
      tailPtr   <= '0;
      count     <= '0;
      dropCount <= '0;
    end else begin
      if (demandAccess) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (queue[i].live && queue[i].addr == demandAddr && !(PTR_W'(i) == headPtr && reqValid))
            queue[i].live <= 1'b0;
        end
      end
      if (pop) begin
        queue[headPtr].live <= 1'b0;
        headPtr             <= headPtr + 1'b1;
      end
      if (enqueue) begin
        queue[tailPtr] <= '{live: 1'b1, addr: pfAddr};
        tailPtr        <= tailPtr + 1'b1;
      end
      case ({enqueue, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && dropCount != '1) dropCount <= dropCount + 1'b1;
    end
  end

  assign mem.memReqValid = reqValid;
  assign mem.memReqAddr  = headEntry.addr;
  assign queueCount      = count;

  pf_inflight_table #(
    .ADDR_W   (ADDR_W),
    .INFLIGHT (INFLIGHT)
  ) u_inflight (
    .clk        (clk),
    .rst_n      (rst_n),
    .allocValid (issue),
    .allocAddr  (headEntry.addr),
    .freeValid  (mem.memRespValid),
    .freeAddr   (mem.memRespAddr),
    .lookupAddr (pfAddr),
    .lookupHit  (inflightHit),
    .count      (inflightCount)
  );

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Directed bench for prefetch_issue_queue: one task per scenario, inputs
// driven and outputs sampled on the falling edge.
module tb_prefetch_issue_queue;

  logic        clk;
  logic        rst_n;
  logic        pfReq;
  logic [15:0] pfAddr;
  logic        demandAccess;
  logic [15:0] demandAddr;
  logic [3:0]  queueCount;
  logic [2:0]  inflightCount;
  logic [7:0]  dropCount;

  int checks;
  int passes;

  prefetch_issue_queue_if #(.ADDR_W(16)) memIf ();

  prefetch_issue_queue #(
    .ADDR_W   (16),
    .DEPTH    (8),
    .INFLIGHT (4),
    .CNT_W    (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pfReq         (pfReq),
    .pfAddr        (pfAddr),
    .demandAccess  (demandAccess),
    .demandAddr    (demandAddr),
    .mem           (memIf),
    .queueCount    (queueCount),
    .inflightCount (inflightCount),
    .dropCount     (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pfReq              = 1'b0;
    pfAddr             = '0;
    demandAccess       = 1'b0;
    demandAddr         = '0;
    memIf.memReqReady  = 1'b0;
    memIf.memRespValid = 1'b0;
    memIf.memRespAddr  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (memIf.memReqValid !== 1'b0) $display("FAIL reset_valid: got %0h want 0", memIf.memReqValid); else passes++;
    checks++; if (memIf.memReqAddr !== 16'h0) $display("FAIL reset_addr: got %0h want 0", memIf.memReqAddr); else passes++;
    checks++; if (queueCount !== 4'd0) $display("FAIL reset_queue: got %0d want 0", queueCount); else passes++;
    checks++; if (inflightCount !== 3'd0) $display("FAIL reset_inflight: got %0d want 0", inflightCount); else passes++;
    checks++; if (dropCount !== 8'd0) $display("FAIL reset_drop: got %0d want 0", dropCount); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_issue();
    apply_reset();
    memIf.memReqReady = 1'b1;
    pfReq = 1'b1; pfAddr = 16'h0100;
    tick();
    pfReq = 1'b0;
    checks++; if (memIf.memReqValid !== 1'b1) $display("FAIL basic_valid: got %0h want 1", memIf.memReqValid); else passes++;
    checks++; if (memIf.memReqAddr !== 16'h0100) $display("FAIL basic_addr: got %0h want 100", memIf.memReqAddr); else passes++;
    tick();
    checks++; if (inflightCount !== 3'd1) $display("FAIL basic_inflight: got %0d want 1", inflightCount); else passes++;
    checks++; if (queueCount !== 4'd0) $display("FAIL basic_queue: got %0d want 0", queueCount); else passes++;
    checks++; if (memIf.memReqValid !== 1'b0) $display("FAIL basic_idle: got %0h want 0", memIf.memReqValid); else passes++;
    memIf.memRespValid = 1'b1; memIf.memRespAddr = 16'h0100;
    tick();
    memIf.memRespValid = 1'b0;
    checks++; if (inflightCount !== 3'd0) $display("FAIL basic_complete: got %0d want 0", inflightCount); else passes++;
  endtask

  task automatic test_duplicate();
    apply_reset();
    pfReq = 1'b1; pfAddr = 16'h0200;
    tick();
    tick();
    pfReq = 1'b0;
    checks++; if (queueCount !== 4'd1) $display("FAIL dup_queue: got %0d want 1", queueCount); else passes++;
    checks++; if (dropCount !== 8'd1) $display("FAIL dup_drop: got %0d want 1", dropCount); else passes++;
    memIf.memReqReady = 1'b1;
    tick();
    memIf.memReqReady = 1'b0;
    checks++; if (inflightCount !== 3'd1) $display("FAIL dup_issued: got %0d want 1", inflightCount); else passes++;
    pfReq = 1'b1; pfAddr = 16'h0200;
    tick();
    pfReq = 1'b0;
    checks++; if (dropCount !== 8'd2) $display("FAIL dup_inflight_drop: got %0d want 2", dropCount); else passes++;
    checks++; if (queueCount !== 4'd0) $display("FAIL dup_inflight_queue: got %0d want 0", queueCount); else passes++;
    // a duplicate of the address whose response returns this same cycle is still dropped
    memIf.memRespValid = 1'b1; memIf.memRespAddr = 16'h0200;
    pfReq = 1'b1; pfAddr = 16'h0200;
    tick();
    idle_inputs();
    checks++; if (dropCount !== 8'd3) $display("FAIL dup_freeing_drop: got %0d want 3", dropCount); else passes++;
    checks++; if (inflightCount !== 3'd0) $display("FAIL dup_freed: got %0d want 0", inflightCount); else passes++;
  endtask

  task automatic test_full();
    logic stable;
    apply_reset();
    stable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pfReq = 1'b1; pfAddr = 16'h1000 + 16'(i * 16);
      tick();
      if (memIf.memReqValid !== 1'b1 || memIf.memReqAddr !== 16'h1000) stable = 1'b0;
    end
    pfReq = 1'b0;
    checks++; if (queueCount !== 4'd8) $display("FAIL full_queue: got %0d want 8", queueCount); else passes++;
    checks++; if (dropCount !== 8'd1) $display("FAIL full_drop: got %0d want 1", dropCount); else passes++;
    checks++; if (stable !== 1'b1) $display("FAIL full_stall_stable: got %0h want 1 (addr now %0h)", stable, memIf.memReqAddr); else passes++;
  endtask

  task automatic test_squash();
    logic [15:0] issued [4];
    logic [15:0] seq [3];
    int nIssued;
    apply_reset();
    seq[0] = 16'h0010; seq[1] = 16'h0020; seq[2] = 16'h0030;
    for (int i = 0; i < 4; i++) issued[i] = '0;
    for (int i = 0; i < 3; i++) begin
      pfReq = 1'b1; pfAddr = seq[i];
      tick();
    end
    pfReq = 1'b0;
    demandAccess = 1'b1; demandAddr = 16'h0020;
    tick();
    // the presented head must survive a demand hit
    demandAddr = 16'h0010;
    tick();
    demandAccess = 1'b0;
    checks++; if (queueCount !== 4'd3) $display("FAIL squash_queue: got %0d want 3", queueCount); else passes++;
    memIf.memReqReady = 1'b1;
    nIssued = 0;
    for (int c = 0; c < 6; c++) begin
      if (memIf.memReqValid === 1'b1) begin
        if (nIssued < 4) issued[nIssued] = memIf.memReqAddr;
        nIssued++;
      end
      tick();
    end
    memIf.memReqReady = 1'b0;
    checks++; if (nIssued != 2) $display("FAIL squash_issue_count: got %0d want 2", nIssued); else passes++;
    checks++; if (issued[0] !== 16'h0010) $display("FAIL squash_first: got %0h want 10", issued[0]); else passes++;
    checks++; if (issued[1] !== 16'h0030) $display("FAIL squash_second: got %0h want 30", issued[1]); else passes++;
    checks++; if (dropCount !== 8'd0) $display("FAIL squash_drop: got %0d want 0", dropCount); else passes++;
    checks++; if (queueCount !== 4'd0) $display("FAIL squash_drained: got %0d want 0", queueCount); else passes++;
  endtask

  task automatic test_inflight_limit();
    apply_reset();
    memIf.memReqReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pfReq = 1'b1; pfAddr = 16'h00A0 + 16'(i);
      tick();
    end
    pfReq = 1'b0;
    checks++; if (inflightCount !== 3'd4) $display("FAIL limit_inflight: got %0d want 4", inflightCount); else passes++;
    checks++; if (queueCount !== 4'd1) $display("FAIL limit_queue: got %0d want 1", queueCount); else passes++;
    checks++; if (memIf.memReqValid !== 1'b0) $display("FAIL limit_blocked: got %0h want 0", memIf.memReqValid); else passes++;
    memIf.memRespValid = 1'b1; memIf.memRespAddr = 16'hFFFF;
    tick();
    memIf.memRespValid = 1'b0;
    checks++; if (inflightCount !== 3'd4) $display("FAIL limit_unmatched: got %0d want 4", inflightCount); else passes++;
    checks++; if (memIf.memReqValid !== 1'b0) $display("FAIL limit_unmatched_valid: got %0h want 0", memIf.memReqValid); else passes++;
    memIf.memRespValid = 1'b1; memIf.memRespAddr = 16'h00A1;
    memIf.memReqReady = 1'b0;
    tick();
    checks++; if (memIf.memReqValid !== 1'b1) $display("FAIL limit_release_valid: got %0h want 1", memIf.memReqValid); else passes++;
    checks++; if (memIf.memReqAddr !== 16'h00A4) $display("FAIL limit_release_addr: got %0h want a4", memIf.memReqAddr); else passes++;
    checks++; if (inflightCount !== 3'd3) $display("FAIL limit_after_free: got %0d want 3", inflightCount); else passes++;
    // free of A0 and allocate of A4 on the same edge: net count unchanged
    memIf.memRespAddr = 16'h00A0;
    memIf.memReqReady = 1'b1;
    tick();
    idle_inputs();
    checks++; if (inflightCount !== 3'd3) $display("FAIL limit_net_update: got %0d want 3", inflightCount); else passes++;
    checks++; if (queueCount !== 4'd0) $display("FAIL limit_drained: got %0d want 0", queueCount); else passes++;
  endtask

  task automatic test_drop_saturation();
    apply_reset();
    pfReq = 1'b1; pfAddr = 16'h0055;
    tick();
    repeat (256) tick();
    pfReq = 1'b0;
    checks++; if (dropCount !== 8'hFF) $display("FAIL sat_drop: got %0h want ff", dropCount); else passes++;
    checks++; if (queueCount !== 4'd1) $display("FAIL sat_queue: got %0d want 1", queueCount); else passes++;
  endtask

  task automatic test_reset_mid_operation();
    apply_reset();
    memIf.memReqReady = 1'b1;
    pfReq = 1'b1; pfAddr = 16'h0300;
    tick();
    pfAddr = 16'h0310;
    tick();
    tick();
    pfReq = 1'b0;
    checks++; if (dropCount !== 8'd1) $display("FAIL mid_pre_drop: got %0d want 1", dropCount); else passes++;
    checks++; if (inflightCount !== 3'd2) $display("FAIL mid_pre_inflight: got %0d want 2", inflightCount); else passes++;
    pfReq = 1'b1; pfAddr = 16'h0320;
    tick();
    pfReq = 1'b0;
    memIf.memReqReady = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (memIf.memReqValid !== 1'b0) $display("FAIL mid_valid: got %0h want 0", memIf.memReqValid); else passes++;
    checks++; if (memIf.memReqAddr !== 16'h0) $display("FAIL mid_addr: got %0h want 0", memIf.memReqAddr); else passes++;
    checks++; if (queueCount !== 4'd0) $display("FAIL mid_queue: got %0d want 0", queueCount); else passes++;
    checks++; if (inflightCount !== 3'd0) $display("FAIL mid_inflight: got %0d want 0", inflightCount); else passes++;
    checks++; if (dropCount !== 8'd0) $display("FAIL mid_drop: got %0d want 0", dropCount); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    // stale response plus a request that would have been an in-flight duplicate before reset
    memIf.memRespValid = 1'b1; memIf.memRespAddr = 16'h0300;
    pfReq = 1'b1; pfAddr = 16'h0310;
    tick();
    idle_inputs();
    checks++; if (inflightCount !== 3'd0) $display("FAIL mid_stale_resp: got %0d want 0", inflightCount); else passes++;
    checks++; if (dropCount !== 8'd0) $display("FAIL mid_post_drop: got %0d want 0", dropCount); else passes++;
    checks++; if (queueCount !== 4'd1) $display("FAIL mid_post_queue: got %0d want 1", queueCount); else passes++;
    checks++; if (memIf.memReqAddr !== 16'h0310) $display("FAIL mid_post_addr: got %0h want 310", memIf.memReqAddr); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_basic_issue();
    test_duplicate();
    test_full();
    test_squash();
    test_inflight_limit();
    test_drop_saturation();
    test_reset_mid_operation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/prefetch_issue_queue.md
# prefetch_issue_queue

Sits directly downstream of the stride prefetcher and consumes its `memRequest`/`requestAddress` stream. Buffers prefetch addresses in a small queue and discards duplicates of queued or in-flight addresses. Cancels queued prefetches that a demand access has already covered. Issues the remaining addresses to the memory port over a valid/ready handshake, and tracks up to `INFLIGHT` outstanding prefetches until their responses return.

## Interface
Parameters:
- `ADDR_W`, 16: address width.
- `DEPTH`, 8: queue entries; power of two, at least 2.
- `INFLIGHT`, 4: maximum outstanding issued prefetches.
- `CNT_W`, 8: width of the drop counter.

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `pfReq`, in, 1: prefetch request strobe from the prefetcher.
- `pfAddr`, in, ADDR_W: address of the prefetch request.
- `demandAccess`, in, 1: a core demand access occurs this cycle.
- `demandAddr`, in, ADDR_W: address of the demand access.
- `memReqValid`, out, 1: a prefetch is presented to memory.
- `memReqAddr`, out, ADDR_W: address of the presented prefetch.
- `memReqReady`, in, 1: memory accepts the request.
- `memRespValid`, in, 1: a prefetch response is returning.
- `memRespAddr`, in, ADDR_W: address of the returning response.
- `queueCount`, out, $clog2(DEPTH)+1: number of occupied queue slots, including squashed slots not yet popped.
- `inflightCount`, out, $clog2(INFLIGHT)+1: number of outstanding prefetches.
- `dropCount`, out, CNT_W: saturating count of discarded `pfReq`.

## Operation
- **Queue:** circular FIFO. Each entry holds a live bit and an address.
- **Enqueue:** `pfReq` is accepted only if all of the following hold at cycle start:
  - The queue is not full.
  - `pfAddr` matches no live queue entry.
  - `pfAddr` matches no in-flight entry, including one being freed by `memRespValid` this cycle.
  - `pfAddr` does not equal `demandAddr` while `demandAccess` is high.
- **Drop:** a `pfReq` that fails any enqueue condition is discarded and `dropCount` increments, saturating at all-ones. Full is judged on the cycle-start count; a same-cycle pop does not make room.
- **Squash:** when `demandAccess` is high, every live non-head entry whose address equals `demandAddr` loses its live bit. The head is squashed the same way only if it is not currently presented. Squashes do not increment `dropCount`.
- **Skip:** a non-live head is popped at the next edge without being issued, at one entry per cycle.
- **Issue:** `memReqValid` = head live AND `inflightCount < INFLIGHT`. Once `memReqValid` is asserted, `memReqValid` and `memReqAddr` stay stable until the handshake `memReqValid && memReqReady`. On the handshake edge the head is popped and its address is allocated to a free in-flight slot.
- **Complete:** `memRespValid` frees the in-flight slot whose address equals `memRespAddr`. A response with no matching slot is ignored.
- **Simultaneous events:** a free and an allocate in the same cycle use distinct slots. The count update is net: free and allocate cancel. An enqueue and a pop in the same cycle leave `queueCount` unchanged.
- **Address width:** addresses are compared at the full `ADDR_W`. No alignment or masking is applied.

## Timing
- **Reset:** all outputs reset to 0. The queue and in-flight table are emptied and `dropCount` is cleared.
- **Reset mid-operation:** reset discards all tracking. Responses that arrive after reset match nothing and are ignored.
- **Registered outputs:** `memReqValid` and `memReqAddr` depend only on registered state; there is no combinational path from any input.
- **Minimum latency:** `pfReq` at edge N on an empty queue with a free slot gives `memReqValid` high in cycle N+1.
- **Issue rate:** at most one issue per cycle. Back-to-back issues are possible while `memReqReady` stays high.
- **Counters:** `queueCount`, `inflightCount` and `dropCount` update at the same edge as the event that changes them.

## Structure
- **Package `prefetch_pkg`:**
  - `ADDR_W` default.
  - `pf_entry_t` {live, addr}.
  - `inflight_entry_t` {valid, addr}.
  - Shared with the prefetcher so that `requestAddress` width stays consistent.
- **Sub-module `pf_inflight_table`:**
  - INFLIGHT-entry CAM with an alloc port (lowest free slot) and a free-by-address port.
  - Match output for the duplicate check.
  - Count output.
- **Top level:** the FIFO, squash logic, issue handshake and drop counter.

## Test plan
- **Basic issue:** reset, then `pfReq` with address 0x0100 and `memReqReady`=1 → `memReqValid` with 0x0100 in the next cycle. One cycle later `inflightCount`=1. `memRespValid` with 0x0100 → `inflightCount`=0.
- **Duplicate:** `pfReq` 0x0200 twice, with `memReqReady`=0 → `queueCount`=1, `dropCount`=1. After issue, `pfReq` 0x0200 is dropped again (in flight) and `dropCount`=2.
- **Full:** with `memReqReady`=0, send 9 distinct `pfReq` → `queueCount`=8 and `dropCount`=1. `memReqAddr` stays at the first address throughout the stall.
- **Squash:** queue 0x10, 0x20, 0x30 with `memReqReady`=0, then `demandAccess` with 0x20. Release ready → issued sequence is 0x10, 0x30; `dropCount` unchanged.
- **In-flight limit:** 4 issues without responses → `memReqValid` stays 0 with the fifth entry queued. A response for the second address → fifth issued on the next cycle. An unmatched response 0xFFFF changes nothing.
- **Reset mid-operation:** assert `rst_n` low mid-operation → all outputs 0 immediately. A stale `memRespValid` after release is ignored; `dropCount`=0.
